dec_n_seq: RTL and testbench

Parametrised, registered N-to-2^N one-hot decoder with a per-slot dwell timer, plus a scan mode that walks the outputs in order.
- Direct mode: decodes one handshaked address into a timed one-hot strobe.
- Scan mode: a free-running ring sequencer, used for select lines, row/column strobes and LED/segment multiplexing.
- This block succeeds the fixed 3-to-8 combinational decoder.

---
 rtl/dec_n_seq.sv | 114 +++++++++++
 tb/tb_dec_n_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_n_seq.sv
// Registered N-to-2^N one-hot decoder with per-slot dwell timer and scan mode.
// Define DEC_N_SEQ_ACTIVE_LOW_EN to drive y active-low (idle all ones).
module dec_n_seq #(
    parameter int N       = 3,
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic [N-1:0]       a,
    input  logic               a_valid,
    output logic               a_ready,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2**N-1:0]    y,
    output logic [N-1:0]       idx,
    output logic               busy,
    output logic               wrap
);

    localparam int W = 2**N;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DIRECT = 2'd1;
    localparam logic [1:0] SCAN   = 2'd2;

    localparam logic [W-1:0] ONE = W'(1);

    logic [1:0]         state;
    logic [W-1:0]       y_q;
    logic [DWELL_W-1:0] cnt;
    logic [N-1:0]       idx_nxt;
    logic               slot_end;

    assign a_ready  = en & ~mode & (state == IDLE);
    assign idx_nxt  = idx + N'(1);
    assign slot_end = (cnt == '0);

`ifdef DEC_N_SEQ_ACTIVE_LOW_EN
    assign y = ~y_q;
`else
    assign y = y_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            y_q   <= '0;
            idx   <= '0;
            busy  <= 1'b0;
            wrap  <= 1'b0;
            cnt   <= '0;
        end else if (!en) begin
            // abort: idx deliberately keeps its last value
            state <= IDLE;
            y_q   <= '0;
            busy  <= 1'b0;
            wrap  <= 1'b0;
            cnt   <= '0;
        end else begin
            wrap <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (mode) begin
                        state <= SCAN;
                        y_q   <= ONE;
                        idx   <= '0;
                        busy  <= 1'b1;
                        cnt   <= dwell;
                    end else if (a_valid) begin
                        state <= DIRECT;
                        y_q   <= ONE << a;
                        idx   <= a;
                        busy  <= 1'b1;
                        cnt   <= dwell;
                    end else begin
                        y_q  <= '0;
                        busy <= 1'b0;
                    end
                end
                DIRECT: begin
                    if (slot_end) begin
                        state <= IDLE;
                        y_q   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - DWELL_W'(1);
                    end
                end
                SCAN: begin
                    if (!slot_end) begin
                        cnt <= cnt - DWELL_W'(1);
                    end else if (!mode) begin
                        state <= IDLE;
                        y_q   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        // no gap: next slot starts on this same edge
                        idx  <= idx_nxt;
                        y_q  <= ONE << idx_nxt;
                        cnt  <= dwell;
                        wrap <= (idx == '1);
                    end
                end
                default: begin
                    state <= IDLE;
                    y_q   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dec_n_seq.sv
// Scoreboard bench for dec_n_seq: stimulus pushes expected slot cycles,
// a negedge monitor pops and compares whenever busy is high.
module tb_dec_n_seq;

    typedef struct {
        logic [7:0] y;
        logic [2:0] idx;
        logic       wrap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       mode;
    logic [2:0] a;
    logic       a_valid;
    logic       a_ready;
    logic [3:0] dwell;
    logic [7:0] y;
    logic [2:0] idx;
    logic       busy;
    logic       wrap;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    exp_t e;

    dec_n_seq #(.N(3), .DWELL_W(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .mode(mode),
        .a(a),
        .a_valid(a_valid),
        .a_ready(a_ready),
        .dwell(dwell),
        .y(y),
        .idx(idx),
        .busy(busy),
        .wrap(wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] phys(input logic [7:0] v);
`ifdef DEC_N_SEQ_ACTIVE_LOW_EN
        return ~v;
`else
        return v;
`endif
    endfunction

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input int yi, input int ii, input bit w);
        exp_t r;
        r.y    = 8'(1 << yi);
        r.idx  = 3'(ii);
        r.wrap = w;
        return r;
    endfunction

    always @(negedge clk) begin
        if (busy) begin
            if (exp_q.size() == 0) begin
                check("busy_unexpected", {31'b0, busy}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("slot", {y, idx, wrap}, {phys(e.y), e.idx, e.wrap});
            end
        end else begin
            check("idle", {y, wrap}, {phys(8'h00), 1'b0});
        end
    end

    task automatic direct_txn(input int aa, input int dd);
        a       = 3'(aa);
        dwell   = 4'(dd);
        a_valid = 1'b1;
        for (int c = 0; c <= dd; c++) exp_q.push_back(mk(aa, aa, 1'b0));
        @(negedge clk);
        check("ready_idle", {31'b0, a_ready}, 32'd1);
        tick();
        a       = 3'($urandom);
        dwell   = 4'($urandom);
        a_valid = 1'b1;
        repeat (dd + 1) begin
            @(negedge clk);
            check("ready_busy", {31'b0, a_ready}, 32'd0);
            tick();
        end
        a_valid = 1'b0;
        @(negedge clk);
        check("ready_gap", {31'b0, a_ready}, 32'd1);
        tick();
    endtask

    task automatic abort_txn(input int aa);
        a       = 3'(aa);
        dwell   = 4'd15;
        a_valid = 1'b1;
        for (int c = 0; c < 9; c++) exp_q.push_back(mk(aa, aa, 1'b0));
        @(negedge clk);
        check("ready_pre_abort", {31'b0, a_ready}, 32'd1);
        tick();
        a_valid = 1'b0;
        repeat (8) tick();
        en = 1'b0;
        #1;
        check("ready_en_low", {31'b0, a_ready}, 32'd0);
        tick();
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_idx", {29'b0, idx}, 32'(aa));
        check("abort_y", {24'b0, y}, {24'b0, phys(8'h00)});
        en = 1'b1;
        #1;
        check("ready_reen", {31'b0, a_ready}, 32'd1);
        tick();
    endtask

    function automatic int pick(input int dm, input int s);
        if (dm == 0) return 0;
        if (dm == 1) return (s == 0) ? 1 : 3;
        return ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
    endfunction

    task automatic scan_run(input int n, input int dm, input bit ab);
        int d;
        int dn;
        int i;
        d     = pick(dm, 0);
        dwell = 4'(d);
        mode  = 1'b1;
        tick();
        for (int s = 0; s < n; s++) begin
            i = s % 8;
            for (int c = 0; c <= d; c++)
                exp_q.push_back(mk(i, i, (c == 0) && (s > 0) && (i == 0)));
            dn    = pick(dm, s + 1);
            dwell = 4'(dn);
            if (s == n - 1 && ab) begin
                repeat (d) tick();
                en = 1'b0;
                tick();
            end else begin
                if (s == n - 1) mode = 1'b0;
                repeat (d + 1) tick();
            end
            d = dn;
        end
        check("scan_end_busy", {31'b0, busy}, 32'd0);
        if (ab) begin
            check("scan_abort_idx", {29'b0, idx}, 32'((n - 1) % 8));
            check("scan_abort_wrap", {31'b0, wrap}, 32'd0);
            mode = 1'b0;
            en   = 1'b1;
        end
        #1;
        check("scan_ready", {31'b0, a_ready}, 32'd1);
        tick();
        check("scan_drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic reset_mid_scan();
        dwell = 4'd0;
        mode  = 1'b1;
        for (int s = 0; s < 5; s++) begin
            tick();
            exp_q.push_back(mk(s, s, 1'b0));
        end
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_y", {24'b0, y}, {24'b0, phys(8'h00)});
        check("rst_idx", {29'b0, idx}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_wrap", {31'b0, wrap}, 32'd0);
        check("rst_ready_scan", {31'b0, a_ready}, {31'b0, en & ~mode});
        exp_q.delete();
        mode = 1'b0;
        #1;
        check("rst_ready_dir", {31'b0, a_ready}, 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b1;
        en      = 1'b0;
        mode    = 1'b0;
        a       = '0;
        a_valid = 1'b0;
        dwell   = '0;
        #1;
        rst_n = 1'b0;
        #1;
        check("init_y", {24'b0, y}, {24'b0, phys(8'h00)});
        check("init_idx", {29'b0, idx}, 32'd0);
        check("init_busy", {31'b0, busy}, 32'd0);
        check("init_wrap", {31'b0, wrap}, 32'd0);
        check("init_ready_off", {31'b0, a_ready}, 32'd0);
        en = 1'b1;
        #1;
        check("init_ready_on", {31'b0, a_ready}, 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        direct_txn(5, 2);
        direct_txn(2, 3);
        direct_txn(7, 0);
        for (int k = 0; k < 12; k++) begin
            direct_txn($urandom_range(0, 7),
                       ($urandom_range(0, 5) == 0) ? 15 :
                       int'($urandom_range(0, 4)));
            repeat ($urandom_range(0, 2)) tick();
        end
        check("direct_drain", 32'(exp_q.size()), 32'd0);

        abort_txn(6);
        abort_txn(1);
        check("abort_drain", 32'(exp_q.size()), 32'd0);

        scan_run(20, 0, 1'b0);
        scan_run(6, 1, 1'b0);
        scan_run(15, 2, 1'b0);
        scan_run(8, 0, 1'b1);
        scan_run(13, 2, 1'b1);
        direct_txn(3, 1);

        reset_mid_scan();
        direct_txn(4, 2);
        repeat (3) tick();
        check("final_drain", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
